// File: rtl/cpu_pkg.sv
// Shared CPU-wide constants and the fetch queue slot layout.
package cpu_pkg;
    localparam int XLEN = 32;
    localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] instr;
        logic            filled;
    } fetch_entry_t;
endpackage

// File: rtl/fetch_slot_ram.sv
// Fetch queue storage: a slot is allocated with its PC, later filled with its
// instruction, and read at the head. A clear drops every filled bit at once.
module fetch_slot_ram
    import cpu_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            clear,
    input  logic            alloc_en,
    input  logic [AW-1:0]   alloc_ptr,
    input  logic [XLEN-1:0] alloc_pc,
    input  logic            fill_en,
    input  logic [AW-1:0]   fill_ptr,
    input  logic [XLEN-1:0] fill_instr,
    input  logic [AW-1:0]   rd_ptr,
    output logic [XLEN-1:0] rd_pc,
    output logic [XLEN-1:0] rd_instr,
    output logic            rd_filled
);
    fetch_entry_t slots [DEPTH];

    // Allocation always targets a free slot and filling an allocated one,
    // so the two write ports never collide on the same entry.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) slots[i] <= '0;
        end else if (clear) begin
            for (int i = 0; i < DEPTH; i++) slots[i].filled <= 1'b0;
        end else begin
            if (alloc_en) begin
                slots[alloc_ptr].pc     <= alloc_pc;
                slots[alloc_ptr].filled <= 1'b0;
            end
            if (fill_en) begin
                slots[fill_ptr].instr  <= fill_instr;
                slots[fill_ptr].filled <= 1'b1;
            end
        end
    end

    assign rd_pc     = slots[rd_ptr].pc;
    assign rd_instr  = slots[rd_ptr].instr;
    assign rd_filled = slots[rd_ptr].filled;
endmodule

// File: rtl/if_id_fetch_queue.sv
// Fetch stage: issues imem requests for pc_i, pairs in-order responses with
// their PCs, and hands {pc, instr} to decode. A flush discards everything in flight.
module if_id_fetch_queue
    import cpu_pkg::*;
#(
    parameter int          DEPTH         = 2,
    parameter logic [31:0] PC_RESET_ADDR = 32'h0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] pc_i,
    output logic        pc_advance_o,
    input  logic        flush_i,
    output logic        imem_req_valid,
    output logic [31:0] imem_req_addr,
    input  logic        imem_req_ready,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    output logic        id_valid,
    output logic [31:0] id_pc,
    output logic [31:0] id_instr,
    input  logic        id_ready
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    // Handshakes: a transfer happens on any cycle where valid && ready; valid
    // never waits on ready, and a stalled request keeps its address stable.
    logic [AW-1:0] wr_ptr, fill_ptr, rd_ptr;
    logic [CW-1:0] count, owed, drop_cnt;
    logic          fire, consume, fill_en, drop_rsp, owed_rsp, rd_filled;

    assign imem_req_valid = rst_n && !flush_i && (count < DEPTH_C) && (drop_cnt == '0);
    assign imem_req_addr  = pc_i;
    assign fire           = imem_req_valid && imem_req_ready;
    assign pc_advance_o   = fire;

    assign id_valid = rd_filled && (count != '0) && !flush_i;
    assign consume  = id_valid && id_ready;

    // Stale responses from before a redirect are swallowed before any fill.
    assign drop_rsp = imem_rsp_valid && (drop_cnt != '0);
    assign fill_en  = imem_rsp_valid && (drop_cnt == '0) && (owed != '0) && !flush_i;
    assign owed_rsp = imem_rsp_valid && ((drop_cnt != '0) || (owed != '0));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr   <= '0;
            fill_ptr <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            owed     <= '0;
            drop_cnt <= '0;
        end else if (flush_i) begin
            drop_cnt <= drop_cnt + owed - CW'(owed_rsp);
            wr_ptr   <= '0;
            fill_ptr <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            owed     <= '0;
        end else begin
            drop_cnt <= drop_cnt - CW'(drop_rsp);
            count    <= count + CW'(fire) - CW'(consume);
            owed     <= owed + CW'(fire) - CW'(fill_en);
            wr_ptr   <= wr_ptr + AW'(fire);
            fill_ptr <= fill_ptr + AW'(fill_en);
            rd_ptr   <= rd_ptr + AW'(consume);
        end
    end

    fetch_slot_ram #(.DEPTH(DEPTH), .AW(AW)) u_slots (
        .clk        (clk),
        .rst_n      (rst_n),
        .clear      (flush_i),
        .alloc_en   (fire),
        .alloc_ptr  (wr_ptr),
        .alloc_pc   (pc_i),
        .fill_en    (fill_en),
        .fill_ptr   (fill_ptr),
        .fill_instr (imem_rsp_data),
        .rd_ptr     (rd_ptr),
        .rd_pc      (id_pc),
        .rd_instr   (id_instr),
        .rd_filled  (rd_filled)
    );

    a_rsp_owed: assert property (@(posedge clk) disable iff (!rst_n)
        imem_rsp_valid |-> ((drop_cnt != '0) || (owed != '0)));

    a_reset_pc: assert property (@(posedge clk)
        !rst_n |-> (pc_i == PC_RESET_ADDR));
endmodule
